muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle multiply/divide responder for the single-cycle ALU's MUL/DIV path.
//   The ALU raises valid (one cycle) with mode (0=MUL, 1=DIV) and its operands.
//   This block runs an iterative shift-add multiply or restoring divide, then
//   pulses ready with the result. It sits beside the ALU in the execute stage.
// PARAMETERS
//   DATA_W   32   operand width; product/quotient+remainder width is 2*DATA_W
// PORTS
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   valid    in   1          request strobe from ALU; sampled only in IDLE
//   mode     in   1          0=MUL, 1=DIV; sampled with valid
//   AiA      in   DATA_W     multiplicand / dividend; sampled with valid
//   AiB      in   DATA_W     multiplier / divisor; sampled with valid
//   ready    out  1          result strobe, high exactly one cycle per request
//   busy     out  1          high from accept until the cycle ready is high (inclusive)
//   Mout     out  2*DATA_W   MUL: full product; DIV: {remainder, quotient}
// BEHAVIOUR
//   States: IDLE -> (valid & !mode) MUL | (valid & mode) DIV; MUL/DIV -> DONE
//     after DATA_W iterations; DONE -> IDLE unconditionally.
//   Accept: at the edge where state=IDLE and valid=1, latch AiA, AiB, mode;
//     clear the accumulator; load iteration counter = DATA_W.
//   MUL step, 1 per cycle: if multiplier LSB=1 then acc_hi += multiplicand;
//     shift {carry, acc} right by 1. Keep the carry; no overflow is lost.
//   DIV step, 1 per cycle: shift {rem, quo} left by 1; trial = rem - divisor;
//     if trial >= 0 (unsigned), rem = trial and quo[0] = 1.
//   Latency: ready=1 in the cycle after the edge that reaches DONE. That is the
//     DATA_W+1-th edge after the accepting edge, so 33 cycles for DATA_W=32.
//   Mout is registered. It updates only on entry to DONE and holds until the
//     next DONE.
//   Back-to-back: valid is ignored in MUL, DIV and DONE; no queueing. A request
//     is accepted again from IDLE, i.e. the edge after ready fell.
//   Divide by zero: no early exit; full latency. quotient = all ones and
//     remainder = dividend, per the RISC-V convention.
//   Simultaneous valid and rst_n low: reset wins, and the request is dropped.
//   Reset mid-operation: return to IDLE immediately. ready=0, busy=0, Mout=0.
//     The partial result is discarded.
//   Reset values: state=IDLE, ready=0, busy=0, Mout=0, counter=0.
//   ready/busy are registered outputs and never combinational from valid.
// CONFIGURATION
//   MULDIV_SIGNED_EN defined:
//     - Operands are two's complement.
//     - At accept: take magnitudes and record the result sign(s).
//     - At DONE: negate the product if the signs differ; negate the quotient if
//       the signs differ; the remainder takes the sign of the dividend.
//     - Overflow (-2^(W-1) / -1): quotient = -2^(W-1), remainder = 0.
//     - Latency is unchanged; the sign fix-up is done in the DONE-entry edge.
//   Not defined: all operands unsigned; no sign logic is present.
// TESTING
//   1. MUL 7 x 6 -> ready exactly 33 cycles after the accept edge;
//      Mout=64'h0000_0000_0000_002A.
//   2. MUL FFFF_FFFF x FFFF_FFFF (unsigned) -> Mout=64'hFFFF_FFFE_0000_0001.
//   3. DIV 100 / 7 -> Mout={32'd2, 32'd14}; ready is a single-cycle pulse.
//   4. DIV 5 / 0 -> Mout={32'd5, 32'hFFFF_FFFF} after the full latency.
//   5. Pulse valid again while busy; then assert rst_n=0 at cycle 10 of a DIV ->
//      the second request is ignored; all outputs are 0 during reset; a new MUL
//      3 x 4 after release gives Mout=12.
//   6. With MULDIV_SIGNED_EN: DIV -7 / 2 -> quotient=-3 (FFFF_FFFD),
//      remainder=-1; MUL -3 x 5 -> Mout=64'hFFFF_FFFF_FFFF_FFF1.

Source files
------------

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide responder that sits beside the single-cycle
//   ALU in the execute stage. A one-cycle request is accepted only in IDLE.
//   The block then runs DATA_W iterations of shift-add multiply or restoring
//   divide, and finally pulses ready for one cycle with the registered result.
//
//   Latency: ready is high in the cycle after the (DATA_W+1)-th rising edge
//   that follows the accepting edge, which is 33 cycles for DATA_W = 32.
//
// Configuration macro:
//   MULDIV_SIGNED_EN  When defined, operands are two's complement. Magnitudes
//                     are taken at accept and the signs are restored on the
//                     DONE-entry edge. Latency does not change.
//                     When undefined, everything is unsigned and no sign
//                     logic is built.
//
// Ports:
//   clk    in   1         rising-edge clock
//   rst_n  in   1         asynchronous active-low reset
//   valid  in   1         request strobe; sampled only in IDLE
//   mode   in   1         0 = MUL, 1 = DIV; sampled with valid
//   AiA    in   DATA_W    multiplicand / dividend
//   AiB    in   DATA_W    multiplier / divisor
//   ready  out  1         result strobe, one cycle per request
//   busy   out  1         high from accept through the ready cycle
//   Mout   out  2*DATA_W  MUL: product; DIV: {remainder, quotient}
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic                  mode,
  input  logic [DATA_W-1:0]     AiA,
  input  logic [DATA_W-1:0]     AiB,
  output logic                  ready,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   Mout
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  // acc is {acc_hi, acc_lo}. MUL uses it as {partial product, multiplier}.
  // DIV uses it as {remainder, quotient/dividend}.
  logic [2*DATA_W-1:0]  acc;
  // opb holds the multiplicand (MUL) or the divisor (DIV).
  logic [DATA_W-1:0]    opb;

`ifdef MULDIV_SIGNED_EN
  logic                 neg_q;     // negate product / quotient at DONE entry
  logic                 neg_r;     // negate remainder at DONE entry
`endif

  // Operands as loaded at accept. In the signed build these are magnitudes.
  logic [DATA_W-1:0]    ld_a;
  logic [DATA_W-1:0]    ld_b;

  // One iteration of each algorithm, computed from the current acc.
  logic [DATA_W:0]      mul_sum;
  logic [2*DATA_W-1:0]  mul_next;
  logic [DATA_W:0]      div_rem_sh;
  logic [DATA_W-1:0]    div_quo_sh;
  logic [DATA_W:0]      div_trial;
  logic [2*DATA_W-1:0]  div_next;

  // Final result with the sign fix-up applied, loaded into Mout on DONE entry.
  logic [2*DATA_W-1:0]  result;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block, so that no path through the block leaves it unassigned. An
  // unassigned path would infer a latch.
  always_comb begin
    ld_a = AiA;
    ld_b = AiB;
`ifdef MULDIV_SIGNED_EN
    if (AiA[DATA_W-1]) ld_a = -AiA;
    if (AiB[DATA_W-1]) ld_b = -AiB;
`endif
  end

  always_comb begin
    // Shift-add multiply: add the multiplicand into the upper half when the
    // multiplier LSB is set. Then shift {carry, acc} right by one bit, so the
    // carry out of the add becomes the new MSB and no overflow is lost.
    mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]};
    if (acc[0]) mul_sum = mul_sum + {1'b0, opb};
    mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Restoring divide: shift {rem, quo} left by one bit and try to subtract
    // the divisor. A clear borrow bit means the subtraction fits, so keep it.
    div_rem_sh = acc[2*DATA_W-1:DATA_W-1];
    div_quo_sh = {acc[DATA_W-2:0], 1'b0};
    div_trial  = div_rem_sh - {1'b0, opb};
    if (!div_trial[DATA_W])
      div_next = {div_trial[DATA_W-1:0], div_quo_sh | {{(DATA_W-1){1'b0}}, 1'b1}};
    else
      div_next = {div_rem_sh[DATA_W-1:0], div_quo_sh};
  end

  always_comb begin
    result = acc;
`ifdef MULDIV_SIGNED_EN
    if (state == S_MUL) begin
      if (neg_q) result = -acc;
    end else begin
      if (neg_q) result[DATA_W-1:0]        = -acc[DATA_W-1:0];
      if (neg_r) result[2*DATA_W-1:DATA_W] = -acc[2*DATA_W-1:DATA_W];
    end
`endif
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  // Every register then samples its pre-edge value, whatever order the
  // statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      acc   <= '0;
      opb   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      Mout  <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            state <= mode ? S_DIV : S_MUL;
            count <= CNT_W'(DATA_W);
            busy  <= 1'b1;
            // The upper half of acc is cleared. The lower half holds the
            // multiplier (MUL) or the dividend (DIV).
            acc   <= {{DATA_W{1'b0}}, mode ? ld_a : ld_b};
            opb   <= mode ? ld_b : ld_a;
`ifdef MULDIV_SIGNED_EN
            // A zero divisor keeps the quotient at all ones (-1) whatever
            // the dividend's sign, so the quotient is not negated.
            neg_q <= (AiA[DATA_W-1] ^ AiB[DATA_W-1]) & ~(mode & (AiB == '0));
            neg_r <= AiA[DATA_W-1];
`endif
          end
        end

        S_MUL, S_DIV: begin
          if (count != '0) begin
            acc   <= (state == S_MUL) ? mul_next : div_next;
            count <= count - 1'b1;
          end else begin
            state <= S_DONE;
            Mout  <= result;
            ready <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed test for muldiv_unit. A table of {operation, operands, expected
//   result} records is run through the unit, and latency, pulse shape and
//   result are checked for each record. Hand-written sequences then cover
//   ignored back-to-back requests, result hold, and reset in mid-operation.
//   Under MULDIV_SIGNED_EN the table holds two's-complement cases.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W       = 32;
  localparam int LATENCY = 33;
  localparam int MAX_WAIT = 100;

  logic            clk;
  logic            rst_n;
  logic            valid;
  logic            mode;
  logic [W-1:0]    a_in;
  logic [W-1:0]    b_in;
  logic            ready;
  logic            busy;
  logic [2*W-1:0]  mout;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid),
    .mode  (mode),
    .AiA   (a_in),
    .AiB   (b_in),
    .ready (ready),
    .busy  (busy),
    .Mout  (mout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] expv;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Drive a one-cycle request and return just after the accepting edge.
  task automatic start_op(input logic m, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(negedge clk);
    valid = 1'b1;
    mode  = m;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Count edges after the accept until ready is seen, bounded by MAX_WAIT.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (ready !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full request: check busy at accept, latency, busy in the ready cycle, the
  // result, and that ready and busy both drop after one cycle.
  task automatic run_op(input string name, input logic m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] expv);
    int lat;
    start_op(m, a, b);
    check({name, " busy@accept"}, {63'd0, busy}, 64'd1);
    wait_ready(lat);
    check({name, " latency"}, 64'(lat), 64'(LATENCY));
    check({name, " busy@ready"}, {63'd0, busy}, 64'd1);
    check({name, " result"}, mout, expv);
    @(posedge clk);
    #1;
    check({name, " ready pulse"}, {62'd0, ready, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    int extra;

    valid = 1'b0;
    mode  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    rst_n = 1'b0;

`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{"smul 7x6",        1'b0, 32'd7,          32'd6,          64'h0000_0000_0000_002A});
    vecs.push_back('{"smul -3x5",       1'b0, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1});
    vecs.push_back('{"smul -1x-1",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001});
    vecs.push_back('{"smul min x min",  1'b0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000});
    vecs.push_back('{"sdiv -7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}});
    vecs.push_back('{"sdiv 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,         32'hFFFF_FFFD}});
    vecs.push_back('{"sdiv -7/-2",      1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3}});
    vecs.push_back('{"sdiv overflow",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,         32'h8000_0000}});
    vecs.push_back('{"sdiv 5/0",        1'b1, 32'd5,          32'd0,          {32'd5,         32'hFFFF_FFFF}});
    vecs.push_back('{"sdiv -5/0",       1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF}});
`else
    vecs.push_back('{"mul 7x6",         1'b0, 32'd7,          32'd6,          64'h0000_0000_0000_002A});
    vecs.push_back('{"mul max x max",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{"mul 2^31 x 2",    1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000});
    vecs.push_back('{"mul 0 x 123",     1'b0, 32'd0,          32'd123,        64'd0});
    vecs.push_back('{"div 100/7",       1'b1, 32'd100,        32'd7,          {32'd2,  32'd14}});
    vecs.push_back('{"div 5/0",         1'b1, 32'd5,          32'd0,          {32'd5,  32'hFFFF_FFFF}});
    vecs.push_back('{"div max/16",      1'b1, 32'hFFFF_FFFF,  32'h10,         {32'hF,  32'h0FFF_FFFF}});
    vecs.push_back('{"div max/1",       1'b1, 32'hFFFF_FFFF,  32'd1,          {32'd0,  32'hFFFF_FFFF}});
    vecs.push_back('{"div 7/9",         1'b1, 32'd7,          32'd9,          {32'd7,  32'd0}});
    vecs.push_back('{"div max/max",     1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0,  32'd1}});
`endif

    // Reset state, with a request held during reset that must be dropped.
    valid = 1'b1;
    mode  = 1'b1;
    a_in  = 32'd9;
    b_in  = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {ready, busy, mout}, 66'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset", {62'd0, ready, busy}, 64'd0);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].expv);

    // Known result, then a MUL with a DIV request pulsed while busy. The DIV
    // must be ignored, and Mout must hold the old result until the MUL is done.
    run_op("div 100/7 pre", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
    start_op(1'b0, 32'd7, 32'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    valid = 1'b1;
    mode  = 1'b1;
    a_in  = 32'd100;
    b_in  = 32'd7;
    @(negedge clk);
    valid = 1'b0;
    check("mout hold while busy", mout, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    wait_ready(lat);
    check("b2b latency", 64'(lat + 6), 64'(LATENCY));
    check("b2b result", mout, 64'h2A);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1 || busy === 1'b1) extra++;
    end
    check("b2b no second op", 64'(extra), 64'd0);

    // Reset at cycle 10 of a DIV, with a second request pulsed while busy.
    start_op(1'b1, 32'd100, 32'd7);
    @(negedge clk);
    valid = 1'b1;
    mode  = 1'b0;
    a_in  = 32'd9;
    b_in  = 32'd9;
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-op reset outputs", {ready, busy, mout}, 66'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset held outputs", {ready, busy, mout}, 66'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle after mid-op reset", {62'd0, ready, busy}, 64'd0);
    run_op("mul 3x4 after reset", 1'b0, 32'd3, 32'd4, 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
